// File: rtl/float_pkg.sv
// Shared IEEE-754 single-precision constants, converter states and field packing.
// Used by both fixed_to_float_seq and float_to_fixed.
package float_pkg;

    localparam int FLT_BIAS  = 127;
    localparam int FLT_EXP_W = 8;
    localparam int FLT_MAN_W = 23;

    typedef enum logic {
        IDLE = 1'b0,
        NORM = 1'b1
    } conv_state_t;

    function automatic logic [31:0] pack(
        input logic                 sign,
        input logic [FLT_EXP_W-1:0] exp,
        input logic [FLT_MAN_W-1:0] man
    );
        return {sign, exp, man};
    endfunction

endpackage

// File: rtl/fixed_to_float_seq.sv
// Signed fixed point (data / 2^FRAC_BITS) to IEEE-754 single, exact, normalised one bit per cycle.
// Latency k+1 cycles from accept (k = leading zeros of |data|); start is ignored while busy.
module fixed_to_float_seq
    import float_pkg::*;
#(
    parameter int WIDTH     = 22,
    parameter int FRAC_BITS = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] data,
    output logic             busy,
    output logic             done,
    output logic [31:0]      result
);

    localparam logic [8:0] EXP_INIT = 9'(FLT_BIAS + (WIDTH - 1 - FRAC_BITS));
    localparam int         MAN_PAD  = FLT_MAN_W - (WIDTH - 1);

    conv_state_t        state;
    logic               sign;
    logic [WIDTH-1:0]   mag;
    logic [8:0]         exp;
    logic [WIDTH-1:0]   data_abs;
    logic [FLT_MAN_W-1:0] man;

    // Two's-complement magnitude; the most negative input maps to 2^(WIDTH-1), still in range.
    assign data_abs = data[WIDTH-1] ? (~data + 1'b1) : data;

    // Implicit leading one dropped, remaining bits left-aligned into the mantissa field.
    assign man = FLT_MAN_W'(mag[WIDTH-2:0]) << MAN_PAD;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            sign   <= 1'b0;
            mag    <= '0;
            exp    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= 32'h0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sign  <= data[WIDTH-1];
                        mag   <= data_abs;
                        exp   <= EXP_INIT;
                        busy  <= 1'b1;
                        state <= NORM;
                    end
                end
                NORM: begin
                    if (mag == '0) begin
                        result <= 32'h0;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end else if (mag[WIDTH-1]) begin
                        result <= pack(sign, exp[FLT_EXP_W-1:0], man);
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        mag <= mag << 1;
                        exp <= exp - 9'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fixed_to_float_seq.sv
// Directed-vector bench for fixed_to_float_seq with hand-computed float results and latencies.
module tb_fixed_to_float_seq;

    localparam int WIDTH     = 22;
    localparam int FRAC_BITS = 20;

    logic             clk;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] data;
    logic             busy;
    logic             done;
    logic [31:0]      result;

    int n_checks = 0;
    int n_fails  = 0;

    fixed_to_float_seq #(.WIDTH(WIDTH), .FRAC_BITS(FRAC_BITS)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .data   (data),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Caller is 1 time unit past a posedge with the DUT idle.
    task automatic do_conv(input string tag, input logic [WIDTH-1:0] d,
                           input logic [31:0] exp_res, input int exp_lat);
        int lat;
        start = 1'b1;
        data  = d;
        step();
        start = 1'b0;
        check_eq({tag, "_busy_at_accept"}, 32'(busy), 32'd1);
        lat = 0;
        while (!done && lat < 40) begin
            step();
            lat++;
            if (!done) check_eq({tag, "_busy_mid"}, 32'(busy), 32'd1);
        end
        check_eq({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check_eq({tag, "_result"}, result, exp_res);
        check_eq({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        step();
        check_eq({tag, "_done_pulse"}, 32'(done), 32'd0);
        check_eq({tag, "_result_hold"}, result, exp_res);
    endtask

    initial begin
        int n_done;
        int last_cyc;
        int cyc;

        reset = 1'b1;
        start = 1'b0;
        data  = '0;
        step();
        step();
        check_eq("reset_busy", 32'(busy), 32'd0);
        check_eq("reset_done", 32'(done), 32'd0);
        check_eq("reset_result", result, 32'h0);
        reset = 1'b0;
        step();

        do_conv("pos_one",   22'h100000, 32'h3F800000, 2);
        do_conv("neg_one",   22'h300000, 32'hBF800000, 2);
        do_conv("most_neg",  22'h200000, 32'hC0000000, 1);
        do_conv("lsb",       22'h000001, 32'h35800000, 22);
        do_conv("max_pos",   22'h1FFFFF, 32'h3FFFFFF8, 2);
        do_conv("half",      22'h080000, 32'h3F000000, 3);
        do_conv("zero",      22'h000000, 32'h00000000, 1);

        // Second start while busy must be ignored.
        start = 1'b1;
        data  = 22'h000001;
        step();
        start = 1'b0;
        step();
        step();
        start = 1'b1;
        data  = 22'h100000;
        step();
        start = 1'b0;
        n_done = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (done) n_done++;
        end
        check_eq("busy_start_done_count", 32'(n_done), 32'd1);
        check_eq("busy_start_result", result, 32'h35800000);

        // Reset mid-conversion discards it.
        start = 1'b1;
        data  = 22'h000001;
        step();
        start = 1'b0;
        repeat (5) step();
        reset = 1'b1;
        #1;
        check_eq("midrst_busy", 32'(busy), 32'd0);
        check_eq("midrst_result", result, 32'h0);
        check_eq("midrst_done", 32'(done), 32'd0);
        step();
        reset = 1'b0;
        n_done = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (done) n_done++;
        end
        check_eq("midrst_no_done", 32'(n_done), 32'd0);
        do_conv("after_rst", 22'h100000, 32'h3F800000, 2);

        // Start held high, data alternating between conversions.
        start    = 1'b1;
        data     = 22'h100000;
        n_done   = 0;
        last_cyc = 0;
        cyc      = 0;
        while (n_done < 4 && cyc < 60) begin
            step();
            cyc++;
            if (done) begin
                check_eq("b2b_result", result, (n_done % 2 == 0) ? 32'h3F800000 : 32'hBF800000);
                if (n_done > 0) check_eq("b2b_gap", 32'(cyc - last_cyc), 32'd3);
                last_cyc = cyc;
                n_done++;
                data = (n_done % 2 == 1) ? 22'h300000 : 22'h100000;
            end
        end
        check_eq("b2b_count", 32'(n_done), 32'd4);
        start = 1'b0;
        repeat (5) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
